// File: rtl/aes_round_ctrl.sv
// Round sequencer for an iterative AES core: takes one block request, walks the
// core through NUM_ROUNDS rounds of STAGES cycles each and registers the result.
module aes_round_ctrl #(
  parameter int unsigned NUM_ROUNDS = 10,
  parameter int unsigned STAGES     = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  output logic         accept,
  output logic [3:0]   rndNo,
  output logic         enbKS,
  input  logic [127:0] core_result,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  localparam int unsigned PHASE_W = (STAGES > 1) ? $clog2(STAGES) : 1;
  localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(STAGES - 1);
  localparam logic [3:0]         ROUND_LAST = 4'(NUM_ROUNDS);

  generate
    if (NUM_ROUNDS > 15 || NUM_ROUNDS == 0 || STAGES == 0) begin : g_param_check
      $error("aes_round_ctrl: NUM_ROUNDS must be 1..15 and STAGES >= 1");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_CAPT = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [3:0]           rnd_q, rnd_d;
  logic [PHASE_W-1:0]   phase_q, phase_d;
  logic                 out_valid_q, out_valid_d;
  logic [127:0]         out_data_q, out_data_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rnd_q       <= '0;
      phase_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      rnd_q       <= rnd_d;
      phase_q     <= phase_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    rnd_d       = rnd_q;
    phase_d     = phase_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_RUN;
          rnd_d   = 4'd1;
          phase_d = '0;
        end
      end
      S_RUN: begin
        if (phase_q == PHASE_LAST) begin
          phase_d = '0;
          if (rnd_q < ROUND_LAST) begin
            rnd_d = rnd_q + 4'd1;
          end else begin
            // rndNo drops to 0 already in the capture cycle
            state_d = S_CAPT;
            rnd_d   = '0;
          end
        end else begin
          phase_d = phase_q + PHASE_W'(1);
        end
      end
      S_CAPT: begin
        // accept was gated on a free slot, so nothing unconsumed is overwritten here
        out_data_d  = core_result;
        out_valid_d = 1'b1;
        rnd_d       = '0;
        state_d     = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        rnd_d   = '0;
        phase_d = '0;
      end
    endcase
  end

  always_comb begin
    in_ready  = (state_q == S_IDLE) && (!out_valid_q || out_ready);
    accept    = in_valid && in_ready;
    enbKS     = (state_q == S_RUN) && (phase_q == PHASE_LAST);
    busy      = (state_q == S_RUN) || (state_q == S_CAPT);
    rndNo     = rnd_q;
    out_valid = out_valid_q;
    out_data  = out_data_q;
  end

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Randomized bench for aes_round_ctrl, checked every cycle against a
// cycle-offset model of the block schedule plus literal FIPS-197 pins.
module tb_aes_round_ctrl;

  localparam int NR  = 10;
  localparam int ST  = 4;
  localparam int LAT = NR * ST + 1;
  localparam logic [127:0] FIPS_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic         accept;
  logic [3:0]   rndNo;
  logic         enbKS;
  logic [127:0] core_result;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         busy;

  aes_round_ctrl #(.NUM_ROUNDS(NR), .STAGES(ST)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .accept(accept), .rndNo(rndNo), .enbKS(enbKS), .core_result(core_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // core stand-in: random data, or the FIPS ciphertext while hold is set
  bit hold = 1'b0;
  initial begin
    core_result = '0;
    forever begin
      @(posedge clk);
      #2;
      core_result = hold ? FIPS_CT : {$urandom, $urandom, $urandom, $urandom};
    end
  end

  // model: a block accepted in cycle T sits at offset d = cycle - T
  int           cyc = 0;
  int           start = -1;
  bit           ov = 1'b0;
  logic [127:0] od = '0;
  int cnt_enb = 0, cnt_acc = 0, cnt_xfer = 0;

  always @(negedge clk) begin
    int d, er;
    bit eb, ee, eir, eacc;
    cyc++;
    if (rst) begin
      start = -1;
      ov    = 1'b0;
      od    = '0;
      check("rst_rndNo", rndNo, 0);
      check("rst_busy", busy, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_enbKS", enbKS, 0);
    end else begin
      d    = (start >= 0) ? cyc - start : -1;
      eb   = (d >= 1) && (d <= LAT);
      er   = (d >= 1 && d <= NR * ST) ? (d - 1) / ST + 1 : 0;
      ee   = (d >= ST) && (d <= NR * ST) && (d % ST == 0);
      eir  = !eb && (!ov || out_ready);
      eacc = in_valid && eir;
      check("busy", busy, eb);
      check("rndNo", rndNo, er);
      check("enbKS", enbKS, ee);
      check("in_ready", in_ready, eir);
      check("accept", accept, eacc);
      check("out_valid", out_valid, ov);
      check("out_data", out_data, od);
      cnt_enb  += int'(enbKS);
      cnt_acc  += int'(accept);
      cnt_xfer += int'(out_valid && out_ready);
      if (d == LAT) begin
        ov = 1'b1;
        od = core_result;
      end else if (ov && out_ready) begin
        ov = 1'b0;
      end
      if (eacc) start = cyc;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // one FIPS-197 C.1 block with stray in_valid pulses during RUN
  task automatic run_fips(input string tag);
    int k, e0, a0;
    hold = 1'b1;
    out_ready = 1'b1;
    step(2);
    e0 = cnt_enb;
    a0 = cnt_acc;
    in_valid = 1'b1;
    step(1);
    in_valid = 1'b0;
    k = 1;
    while (!out_valid && k < 100) begin
      in_valid = (k == 10 || k == 25);
      step(1);
      k++;
    end
    in_valid = 1'b0;
    check({tag, "_latency"}, k, 42);
    check({tag, "_ct"}, out_data, FIPS_CT);
    check({tag, "_enb_count"}, cnt_enb - e0, 10);
    check({tag, "_acc_count"}, cnt_acc - a0, 1);
    step(1);
    hold = 1'b0;
  endtask

  initial begin
    int x0;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    step(3);
    rst = 1'b0;
    step(2);

    run_fips("fips1");

    // backpressure: result held for 100 cycles, then one transfer
    out_ready = 1'b0;
    in_valid = 1'b1;
    step(1);
    in_valid = 1'b0;
    step(LAT + 100);
    check("bp_out_valid", out_valid, 1);
    check("bp_in_ready", in_ready, 0);
    x0 = cnt_xfer;
    out_ready = 1'b1;
    step(1);
    out_ready = 1'b0;
    check("bp_xfer_count", cnt_xfer - x0, 1);
    check("bp_in_ready_after", in_ready, 1);
    step(3);

    // back-to-back
    x0 = cnt_xfer;
    in_valid = 1'b1;
    out_ready = 1'b1;
    step(85);
    check("b2b_xfer_count", cnt_xfer - x0, 2);
    in_valid = 1'b0;
    step(50);

    // asynchronous reset mid-block
    in_valid = 1'b1;
    step(1);
    in_valid = 1'b0;
    step(19);
    #2 rst = 1'b1;
    #1;
    check("async_busy", busy, 0);
    check("async_rndNo", rndNo, 0);
    check("async_out_valid", out_valid, 0);
    check("async_out_data", out_data, 0);
    step(2);
    rst = 1'b0;
    step(60);
    run_fips("fips2");

    // random traffic
    for (int i = 0; i < 2000; i++) begin
      in_valid  = ($urandom_range(0, 3) == 0);
      out_ready = ($urandom_range(0, 1) == 1);
      step(1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step(60);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
